// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer in front of the 18-bit ALU: 8x18 register file,
// operand/ctrl registers toward the ALU, writeback and status-flag latching.
module alu_issue_seq #(
    parameter int DW   = 18,
    parameter int NREG = 8,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_ra,
    input  logic [AW-1:0] instr_rb,
    input  logic [DW-1:0] instr_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_ctrl,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_n,
    input  logic          alu_z,
    input  logic          alu_ovf,
    input  logic          alu_agtb,
    output logic          done,
    output logic          flag_n,
    output logic          flag_z,
    output logic          flag_ovf,
    output logic          flag_agtb,
    output logic          flag_dz,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_rf [NREG];
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_imm;
    logic          r_ldi;
    logic          r_dz;

    logic          w_accept;
    logic [DW-1:0] w_opa;
    logic [DW-1:0] w_opb;
    logic          w_ldi;
    logic          w_dz;

    assign instr_ready = (r_state == S_IDLE);
    assign done        = (r_state == S_WB);
    assign w_accept    = instr_valid && instr_ready;
    assign w_opa       = r_rf[instr_ra];
    assign w_opb       = r_rf[instr_rb];
    assign w_ldi       = (instr_op == 4'hF);
    // Divide/modulo by zero is resolved here so the ALU never sees it.
    assign w_dz        = ((instr_op == 4'h3) || (instr_op == 4'h4)) && (w_opb == '0);
    assign dbg_data    = r_rf[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (w_ldi || w_dz) ? S_WB : S_ISSUE;
            S_ISSUE: w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
            r_rd      <= '0;
            r_imm     <= '0;
            r_ldi     <= 1'b0;
            r_dz      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            flag_ovf  <= 1'b0;
            flag_agtb <= 1'b0;
            flag_dz   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rd  <= instr_rd;
                r_imm <= instr_imm;
                r_ldi <= w_ldi;
                r_dz  <= w_dz;
                // Operands only move for real ALU work; they stay put through ISSUE/WB.
                if (!w_ldi && !w_dz) begin
                    alu_a    <= w_opa;
                    alu_b    <= w_opb;
                    alu_ctrl <= instr_op;
                end
            end
            if (r_state == S_WB) begin
                if (r_ldi) begin
                    r_rf[r_rd] <= r_imm;
                end else if (r_dz) begin
                    r_rf[r_rd] <= '0;
                    flag_n     <= 1'b0;
                    flag_z     <= 1'b1;
                    flag_ovf   <= 1'b0;
                    flag_dz    <= 1'b1;
                end else begin
                    r_rf[r_rd] <= alu_result;
                    flag_n     <= alu_n;
                    flag_z     <= alu_z;
                    flag_ovf   <= alu_ovf;
                    flag_agtb  <= alu_agtb;
                    flag_dz    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: registered ALU stub, instruction-level reference
// model of the register file and flags, directed then random instructions.
module tb_alu_issue_seq;

    localparam int DW   = 18;
    localparam int NREG = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    instr_op;
    logic [2:0]    instr_rd, instr_ra, instr_rb;
    logic [DW-1:0] instr_imm;
    logic [DW-1:0] alu_a, alu_b;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_result;
    logic          alu_n, alu_z, alu_ovf, alu_agtb;
    logic          done;
    logic          flag_n, flag_z, flag_ovf, flag_agtb, flag_dz;
    logic [2:0]    dbg_addr;
    logic [DW-1:0] dbg_data;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int last_acc = 0;

    // Reference state: architectural registers, flags, and ALU-facing registers.
    logic [DW-1:0] m_rf [NREG];
    logic [4:0]    m_flags;  // {n, z, ovf, agtb, dz}
    logic [DW-1:0] m_alu_a, m_alu_b;
    logic [3:0]    m_alu_ctrl;

    alu_issue_seq #(.DW(DW), .NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra),
        .instr_rb(instr_rb), .instr_imm(instr_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z),
        .alu_ovf(alu_ovf), .alu_agtb(alu_agtb),
        .done(done),
        .flag_n(flag_n), .flag_z(flag_z), .flag_ovf(flag_ovf),
        .flag_agtb(flag_agtb), .flag_dz(flag_dz),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: returns {n, z, ovf, agtb, result}; ctrl[3] rotates the result left.
    function automatic logic [DW+3:0] alu_fn(input logic [3:0] c, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic          ovf;
        case (c[2:0])
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a * b;
            3'd3: r = (b == 0) ? '1 : a / b;
            3'd4: r = (b == 0) ? a : a % b;
            3'd5: r = a & b;
            3'd6: r = a | b;
            default: r = a ^ b;
        endcase
        ovf = (c[2:0] == 3'd0) && (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
        if (c[3]) r = {r[DW-2:0], r[DW-1]};
        return {r[DW-1], (r == '0), ovf, ($signed(a) > $signed(b)), r};
    endfunction

    always @(posedge clk) {alu_n, alu_z, alu_ovf, alu_agtb, alu_result} <= alu_fn(alu_ctrl, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_rf[i] = '0;
        m_flags    = '0;
        m_alu_a    = '0;
        m_alu_b    = '0;
        m_alu_ctrl = '0;
    endtask

    // Called just after a negedge with the DUT idle; returns just after a negedge, idle again.
    task automatic run_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                             input logic [2:0] rb, input logic [DW-1:0] imm,
                             input bit keep_valid, input int exp_gap);
        logic [DW-1:0] a, b, exp_val;
        logic [DW+3:0] res;
        bit            direct;
        a = m_rf[ra];
        b = m_rf[rb];
        direct = (op == 4'hF) || (((op == 4'h3) || (op == 4'h4)) && (b == '0));
        instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
        instr_valid = 1'b1;
        #1;
        chk("ready_idle", instr_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if (exp_gap != 0) chk("accept_gap", cyc - last_acc, exp_gap);
        last_acc = cyc;
        if (!keep_valid) instr_valid = 1'b0;
        if (!direct) begin
            m_alu_a = a; m_alu_b = b; m_alu_ctrl = op;
            #1;
            chk("issue_done", done, 0);
            chk("issue_ready", instr_ready, 0);
            chk("issue_alu_a", alu_a, m_alu_a);
            chk("issue_alu_b", alu_b, m_alu_b);
            chk("issue_alu_ctrl", alu_ctrl, m_alu_ctrl);
            @(negedge clk);
        end
        #1;
        chk("wb_done", done, 1);
        chk("wb_ready", instr_ready, 0);
        chk("wb_alu_ctrl", alu_ctrl, m_alu_ctrl);
        chk("wb_alu_ab", {alu_a, alu_b}, {m_alu_a, m_alu_b});
        if (op == 4'hF) begin
            exp_val = imm;
        end else if (direct) begin
            exp_val = '0;
            m_flags = {1'b0, 1'b1, 1'b0, m_flags[1], 1'b1};
        end else begin
            res = alu_fn(op, a, b);
            exp_val = res[DW-1:0];
            m_flags = {res[DW+3:DW], 1'b0};
        end
        m_rf[rd] = exp_val;
        @(negedge clk);
        dbg_addr = rd;
        #1;
        chk("post_done", done, 0);
        chk("post_ready", instr_ready, 1);
        chk("dbg_rd", dbg_data, m_rf[rd]);
        chk("flags", {flag_n, flag_z, flag_ovf, flag_agtb, flag_dz}, m_flags);
    endtask

    initial begin
        logic [3:0]    rop;
        logic [DW-1:0] rimm;
        instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_ra = '0; instr_rb = '0;
        instr_imm = '0; dbg_addr = '0;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_flags", {flag_n, flag_z, flag_ovf, flag_agtb, flag_dz}, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        for (int i = 0; i < NREG; i++) begin
            dbg_addr = i[2:0];
            #1 chk("rst_rf", dbg_data, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_instr(4'hF, 3'd1, 3'd0, 3'd0, 18'h00005, 1'b0, 0);
        run_instr(4'hF, 3'd2, 3'd0, 3'd0, 18'h00003, 1'b0, 2);
        run_instr(4'h0, 3'd3, 3'd1, 3'd2, '0, 1'b0, 2);
        run_instr(4'h1, 3'd4, 3'd2, 3'd1, '0, 1'b0, 3);
        run_instr(4'h1, 3'd5, 3'd1, 3'd1, '0, 1'b0, 3);
        run_instr(4'h3, 3'd6, 3'd1, 3'd0, '0, 1'b0, 3);
        run_instr(4'h2, 3'd7, 3'd1, 3'd2, '0, 1'b0, 2);
        chk("r4_value", m_rf[4], 18'h3FFFE);
        chk("r7_value", m_rf[7], 18'd15);
        run_instr(4'h0, 3'd1, 3'd1, 3'd2, '0, 1'b1, 3);
        run_instr(4'h0, 3'd1, 3'd1, 3'd2, '0, 1'b0, 3);
        chk("r1_after_two_adds", m_rf[1], 18'd11);

        // Reset during ISSUE aborts the add.
        instr_op = 4'h0; instr_rd = 3'd3; instr_ra = 3'd1; instr_rb = 3'd2; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        dbg_addr = 3'd3;
        #1;
        chk("midrst_ready", instr_ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_r3", dbg_data, 0);
        chk("midrst_flags", {flag_n, flag_z, flag_ovf, flag_agtb, flag_dz}, 0);
        chk("midrst_alu", {alu_a, alu_b, alu_ctrl}, 0);
        repeat (2) begin
            @(negedge clk);
            #1 chk("midrst_no_done", done, 0);
        end
        rst_n = 1'b1;
        run_instr(4'hF, 3'd2, 3'd0, 3'd0, 18'h00009, 1'b0, 0);
        dbg_addr = 3'd3;
        #1 chk("midrst_r3_after", dbg_data, 0);

        for (int k = 0; k < 60; k++) begin
            rop  = 4'($urandom_range(0, 15));
            rimm = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            run_instr(rop, 3'($urandom), 3'($urandom), 3'($urandom), rimm, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Instruction issue and writeback sequencer placed directly upstream of the 18-bit ALU. Accepts one instruction at a time over a valid/ready handshake, reads operands from an 8-entry × 18-bit register file, and drives the ALU's operand and control inputs. Waits for the ALU's registered result, writes it back to the destination register and latches the ALU status flags. Also handles load-immediate and divide/modulo-by-zero locally, without using the ALU.

## Interface
- DW, 18: data width; matches ALU operands.
- NREG, 8: register file depth; address width is log2(NREG) = 3.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept; high exactly when state is IDLE.
- instr_op  in  4  ALU ctrl code; 4'hF = LDI (load immediate).
- instr_rd, instr_ra, instr_rb  in  3 each  destination, operand A, operand B indices.
- instr_imm  in  DW  immediate value for LDI.
- alu_a, alu_b  out  DW  ALU operand A/B (registered).
- alu_ctrl  out  4  ALU ctrl (registered).
- alu_result  in  DW  ALU registered result.
- alu_n, alu_z, alu_ovf, alu_agtb  in  1 each  ALU status flags.
- done  out  1  one-cycle pulse when writeback occurs.
- flag_n, flag_z, flag_ovf, flag_agtb, flag_dz  out  1 each  latched status.
- dbg_addr  in  3  debug read index.
- dbg_data  out  DW  combinational read of regfile[dbg_addr].

## Operation
- States: IDLE, ISSUE, WB.
- Accept occurs on a rising edge with instr_valid && instr_ready. At accept, the sequencer latches rd, op and imm, and captures regfile[ra] and regfile[rb].
- IDLE → ISSUE on accept for ops 0x0–0xE, unless divide-by-zero applies.
  - alu_a, alu_b and alu_ctrl load at the accept edge.
  - They hold stable through ISSUE and WB.
- IDLE → WB directly in two cases:
  - LDI (op 0xF).
  - op 3 or 4 with captured B == 0 (divide-by-zero).
- Operands stay untouched in both direct-to-WB cases.
- ISSUE → WB unconditionally. The ALU captures its result on the edge ending ISSUE.
- WB → IDLE unconditionally. On the edge ending WB:
  - ALU op: regfile[rd] ← alu_result; flag_n/z/ovf/agtb ← alu_n/z/ovf/agtb; flag_dz ← 0.
  - LDI: regfile[rd] ← instr_imm; all flags unchanged.
  - Divide-by-zero: regfile[rd] ← 0; flag_z ← 1, flag_dz ← 1, flag_n ← 0, flag_ovf ← 0; flag_agtb unchanged.
- done is high for the whole WB cycle; exactly one cycle per instruction.
- Ops 0x7–0xE are passed to the ALU unmodified. The result written back is whatever the ALU returns, including its ctrl[3] shift.
- All 8 registers are writable; there is no hard-wired zero register.
- instr_* inputs are ignored outside IDLE. Upstream must hold instr_* stable while valid is high and ready is low.
- Reset (rst_n low, any state, asynchronous):
  - state ← IDLE.
  - All regfile entries, alu_a, alu_b, alu_ctrl and all flags ← 0; done ← 0.
  - Any in-flight instruction is aborted with no writeback.
  - instr_ready reads 1 during reset, but no accept can happen until rst_n is high at a rising edge.

## Timing
- ALU op latency, accept edge to writeback edge: 2 cycles (ISSUE, WB). Throughput: 1 instruction per 3 cycles.
- LDI and divide-by-zero latency: 1 cycle (WB only). Throughput: 1 per 2 cycles.
- Read-after-write is safe: writeback completes on the edge ending WB, before the next accept edge, so no forwarding is needed.
- dbg_data shows a written value in the cycle after the WB edge.
- alu_a, alu_b and alu_ctrl must not change during ISSUE. The ALU output is combinational on these inputs before its result register.

## Test plan
- Reset, then LDI r1=5 and LDI r2=3 → each has done for 1 cycle and 2-cycle spacing between accepts; dbg r1=0x00005, dbg r2=0x00003; flags all 0.
- ADD r3=r1+r2 → alu_a=5, alu_b=3, alu_ctrl=0 held for 2 cycles; r3=0x00008; flag_n=0, flag_z=0; done 2 cycles after accept.
- SUB r4=r2−r1 → r4=0x3FFFE, flag_n=1, flag_z=0, flag_agtb=0. Then SUB r5=r1−r1 → r5=0, flag_z=1.
- DIV r6=r1/r0 (r0=0) → no ISSUE cycle; r6=0, flag_dz=1, flag_z=1; alu_ctrl keeps its previous value. A following MUL r7=r1*r2 → r7=15, flag_dz=0.
- Back-to-back with instr_valid held high: ADD r1=r1+r2 then ADD r1=r1+r2 → r1=8 then 11. Second accept is exactly 3 cycles after the first; ready is low in ISSUE and WB.
- Assert rst_n low mid-ISSUE of ADD r3 → no done; r3=0, all flags 0, state IDLE; first accept possible on the first rising edge after rst_n goes high.
